aplic_msi_writer: RTL and testbench
===================================

APLIC_MSI_WRITER -- requirements
Module: aplic_msi_writer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: request queue entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, default 64: MSI target address width.
REQ-003 Parameter EIID_W, default 11: external interrupt identity width.
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 ni_rst  in  1  asynchronous, active-low reset.
REQ-006 i_msi_valid  in  1  domain presents an MSI request.
REQ-007 o_msi_ready  out  1  queue can accept a request.
REQ-008 i_msi_addr  in  ADDR_W  target IMSIC file address; 4-byte aligned.
REQ-009 i_msi_eiid  in  EIID_W  identity to write.
REQ-010 o_awvalid / i_awready / o_awaddr[ADDR_W]  AXI write-address channel.
REQ-011 o_wvalid / i_wready / o_wdata[64] / o_wstrb[8] / o_wlast  AXI write-data channel.
REQ-012 i_bvalid / o_bready / i_bresp[2]  AXI write-response channel.
REQ-013 o_err  out  1  one-cycle pulse on a non-OKAY response.
REQ-014 o_busy  out  1  queue non-empty or a transaction in flight.

Function
REQ-015 Request accepted when i_msi_valid && o_msi_ready; {addr, eiid} pushed into FIFO the same edge.
REQ-016 o_msi_ready = 1 exactly when the FIFO is not full; a push when full is impossible by construction.
REQ-017 Full and empty flags come from pointers with one extra wrap bit; both pointers wrap modulo FIFO_DEPTH.
REQ-018 Simultaneous push and pop when full: o_msi_ready stays 0 that cycle; the pop frees a slot visible the next cycle.
REQ-019 Simultaneous push and pop on any other occupancy: occupancy unchanged.
REQ-020 FSM states: IDLE, SEND, RESP.
REQ-021 IDLE with FIFO non-empty: pop the head into the output registers and go to SEND on the next edge.
REQ-022 IDLE with FIFO empty: remain in IDLE.
REQ-023 SEND: o_awvalid and o_wvalid rise together.
REQ-024 SEND: each valid drops independently, the cycle after its own handshake.
REQ-025 SEND to RESP: when both AW and W handshakes have completed, including when both complete in the same cycle.
REQ-026 RESP: o_bready = 1. On i_bvalid, go to IDLE; if i_bresp != 2'b00, pulse o_err.
REQ-027 A failed MSI is not retried.
REQ-028 o_awaddr = latched addr.
REQ-029 o_wdata = EIID zero-extended to 32 bits, replicated in both 32-bit halves.
REQ-030 o_wstrb = 8'hF0 when addr[2] = 1, else 8'h0F.
REQ-031 o_wlast = o_wvalid (single-beat burst).
REQ-032 Data and address outputs hold stable while their valid is high and unacknowledged.
REQ-033 Latency: at most one transaction in flight.
REQ-034 Minimum latency from accept into an empty FIFO to o_awvalid is 2 cycles (push edge, pop edge).
REQ-035 Back-to-back throughput: one MSI per 3 cycles plus slave stalls.
REQ-036 o_busy = FIFO non-empty || state != IDLE.

Reset
REQ-037 On ni_rst low, regardless of state: FIFO empty, pointers 0, state IDLE.
REQ-038 Reset values: o_awvalid, o_wvalid, o_bready and o_err = 0; o_awaddr, o_wdata and o_wstrb = 0; o_msi_ready = 1; o_busy = 0.
REQ-039 Reset mid-transaction abandons the transaction and all queued requests; no AXI valid is held across reset.
REQ-040 The first valid after reset release appears no earlier than the second rising edge after a push.

Verification
REQ-041 Single request: push addr 0x2800_0000, eiid 5; slave always ready, B OKAY two cycles later -> awaddr 0x2800_0000, wdata 0x0000_0005_0000_0005, wstrb 0x0F, o_err stays 0.
REQ-042 Upper lane: push addr 0x2800_1004, eiid 0x7FF -> wstrb 0xF0, wdata 0x0000_07FF_0000_07FF.
REQ-043 Independent handshakes: awready held low 5 cycles while wready is high -> o_wvalid drops after one cycle, o_awvalid held 5 cycles with a stable address, then RESP.
REQ-044 Full queue: hold B off and push 5 requests with FIFO_DEPTH 4 -> o_msi_ready low after 5 accepts (4 queued + 1 in flight); release B -> all 5 writes emitted in push order.
REQ-045 Error: i_bresp = 2'b10 -> o_err high exactly one cycle, FSM returns to IDLE, next queued request issued.
REQ-046 Reset mid-SEND with 3 queued -> all valids 0 immediately (asynchronous), o_busy 0, o_msi_ready 1, no writes after release.

Source files
------------

// File: rtl/aplic_msi_writer.sv
// aplic_msi_writer: queues MSI requests from an APLIC domain and emits each one as a
// single-beat 64-bit AXI write of the EIID to the target IMSIC interrupt file.
//
// Ports
//   i_clk, ni_rst                       clock, asynchronous active-low reset
//   i_msi_valid / o_msi_ready           request handshake (o_msi_ready = queue not full)
//   i_msi_addr[ADDR_W], i_msi_eiid[EIID_W]  request payload (address 4-byte aligned)
//   o_awvalid / i_awready / o_awaddr    AXI write-address channel
//   o_wvalid / i_wready / o_wdata / o_wstrb / o_wlast  AXI write-data channel
//   i_bvalid / o_bready / i_bresp       AXI write-response channel
//   o_err                               one-cycle pulse on a non-OKAY response
//   o_busy                              queue non-empty or a transaction in flight
module aplic_msi_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned EIID_W     = 11
) (
    input  logic              i_clk,
    input  logic              ni_rst,

    input  logic              i_msi_valid,
    output logic              o_msi_ready,
    input  logic [ADDR_W-1:0] i_msi_addr,
    input  logic [EIID_W-1:0] i_msi_eiid,

    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [ADDR_W-1:0] o_awaddr,

    output logic              o_wvalid,
    input  logic              i_wready,
    output logic [63:0]       o_wdata,
    output logic [7:0]        o_wstrb,
    output logic              o_wlast,

    input  logic              i_bvalid,
    output logic              o_bready,
    input  logic [1:0]        i_bresp,

    output logic              o_err,
    output logic              o_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [EIID_W-1:0] eiid;
    } msi_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    // Request queue: pointers carry one extra wrap bit to tell full from empty.
    msi_req_t        mem [FIFO_DEPTH];
    logic [PTR_W:0]  wr_ptr;
    logic [PTR_W:0]  rd_ptr;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic            pop;
    msi_req_t        head;

    state_t          state;
    state_t          state_d;
    logic            awvalid_d;
    logic            wvalid_d;
    logic            bready_d;
    logic            err_d;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // A full queue never accepts, even if the FSM pops in the same cycle.
    assign push = i_msi_valid && !fifo_full;
    assign head = mem[rd_ptr[PTR_W-1:0]];

    assign o_msi_ready = !fifo_full;
    assign o_busy      = !fifo_empty || (state != IDLE);
    assign o_wlast     = o_wvalid;

    // Queue storage: payload only, emptiness is tracked by the pointers.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= '{addr: i_msi_addr, eiid: i_msi_eiid};
        end
    end

    // Queue pointers.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // FSM state and handshake outputs.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state     <= IDLE;
            o_awvalid <= 1'b0;
            o_wvalid  <= 1'b0;
            o_bready  <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            state     <= state_d;
            o_awvalid <= awvalid_d;
            o_wvalid  <= wvalid_d;
            o_bready  <= bready_d;
            o_err     <= err_d;
        end
    end

    // Next state; AW and W retire independently, RESP once both are done.
    always_comb begin
        state_d   = state;
        awvalid_d = o_awvalid;
        wvalid_d  = o_wvalid;
        bready_d  = o_bready;
        err_d     = 1'b0;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_d   = SEND;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            SEND: begin
                if (o_awvalid && i_awready) begin
                    awvalid_d = 1'b0;
                end
                if (o_wvalid && i_wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                end
            end
            RESP: begin
                if (i_bvalid) begin
                    state_d  = IDLE;
                    bready_d = 1'b0;
                    err_d    = (i_bresp != 2'b00);
                end
            end
            default: begin
                state_d   = IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
            end
        endcase
    end

    // Address/data are loaded only on pop, so they stay stable through SEND.
    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            o_awaddr <= '0;
            o_wdata  <= '0;
            o_wstrb  <= '0;
        end else if (pop) begin
            o_awaddr <= head.addr;
            o_wdata  <= {32'(head.eiid), 32'(head.eiid)};
            // The 32-bit seteipnum register sits in the upper lane when addr[2] is set.
            o_wstrb  <= head.addr[2] ? 8'hF0 : 8'h0F;
        end
    end

endmodule

// File: tb/tb_aplic_msi_writer.sv
// Directed bench for aplic_msi_writer: drives requests and a simple AXI slave,
// logs every AW/W handshake and compares against hand-computed values.
module tb_aplic_msi_writer;

    logic        i_clk = 1'b0;
    logic        ni_rst = 1'b0;
    logic        i_msi_valid = 1'b0;
    logic        o_msi_ready;
    logic [63:0] i_msi_addr = '0;
    logic [10:0] i_msi_eiid = '0;
    logic        o_awvalid;
    logic        i_awready = 1'b1;
    logic [63:0] o_awaddr;
    logic        o_wvalid;
    logic        i_wready = 1'b1;
    logic [63:0] o_wdata;
    logic [7:0]  o_wstrb;
    logic        o_wlast;
    logic        i_bvalid = 1'b0;
    logic        o_bready;
    logic [1:0]  i_bresp = 2'b00;
    logic        o_err;
    logic        o_busy;

    int          vectors = 0;
    int          miscompares = 0;

    // Slave B-channel controls (written by the stimulus block only).
    logic        b_en = 1'b1;
    int          b_lat = 1;
    logic [1:0]  b_resp_v = 2'b00;
    int          b_cnt = 0;

    logic [63:0] aw_q[$];
    logic [63:0] wd_q[$];
    logic [7:0]  ws_q[$];
    int          err_cnt = 0;

    localparam logic [63:0] T4_ADDR [5] = '{64'h2800_0000, 64'h2800_1004, 64'h2800_2000,
                                            64'h2800_3004, 64'h2800_400C};
    localparam logic [10:0] T4_EIID [5] = '{11'd1, 11'd2, 11'd3, 11'd4, 11'd5};
    localparam logic [63:0] T4_DATA [5] = '{64'h0000_0001_0000_0001, 64'h0000_0002_0000_0002,
                                            64'h0000_0003_0000_0003, 64'h0000_0004_0000_0004,
                                            64'h0000_0005_0000_0005};
    localparam logic [7:0]  T4_STRB [5] = '{8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'hF0};

    aplic_msi_writer #(
        .FIFO_DEPTH (4),
        .ADDR_W     (64),
        .EIID_W     (11)
    ) dut (
        .i_clk       (i_clk),
        .ni_rst      (ni_rst),
        .i_msi_valid (i_msi_valid),
        .o_msi_ready (o_msi_ready),
        .i_msi_addr  (i_msi_addr),
        .i_msi_eiid  (i_msi_eiid),
        .o_awvalid   (o_awvalid),
        .i_awready   (i_awready),
        .o_awaddr    (o_awaddr),
        .o_wvalid    (o_wvalid),
        .i_wready    (i_wready),
        .o_wdata     (o_wdata),
        .o_wstrb     (o_wstrb),
        .o_wlast     (o_wlast),
        .i_bvalid    (i_bvalid),
        .o_bready    (o_bready),
        .i_bresp     (i_bresp),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // B responder: raises bvalid b_lat cycles after bready, drops it after the handshake.
    always begin
        @(posedge i_clk);
        #2;
        if (!ni_rst) begin
            i_bvalid = 1'b0;
            b_cnt    = 0;
        end else if (i_bvalid && !o_bready) begin
            i_bvalid = 1'b0;
            i_bresp  = 2'b00;
        end else if (!i_bvalid && o_bready && b_en) begin
            b_cnt++;
            if (b_cnt >= b_lat) begin
                i_bvalid = 1'b1;
                i_bresp  = b_resp_v;
                b_cnt    = 0;
            end
        end
    end

    // Handshake log, sampled mid-cycle while all signals are stable.
    always @(negedge i_clk) begin
        if (ni_rst) begin
            if (o_awvalid && i_awready) aw_q.push_back(o_awaddr);
            if (o_wvalid && i_wready) begin
                wd_q.push_back(o_wdata);
                ws_q.push_back(o_wstrb);
            end
            if (o_err) err_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called in the drive phase (just after a rising edge); returns in the same phase.
    task automatic push(input logic [63:0] a, input logic [10:0] e);
        int n = 0;
        i_msi_valid = 1'b1;
        i_msi_addr  = a;
        i_msi_eiid  = e;
        @(negedge i_clk);
        while (!o_msi_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        chk("push_accept", 64'(n < 50), 64'd1);
        @(posedge i_clk);
        #1;
        i_msi_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge i_clk);
        while (o_busy && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk(tag, 64'(n < 200), 64'd1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [63:0] a, input logic [63:0] d,
                             input logic [7:0] s);
        logic [63:0] ga = '0;
        logic [63:0] gd = '0;
        logic [7:0]  gs = '0;
        chk({tag, "_logged"}, 64'(aw_q.size() > 0 && wd_q.size() > 0), 64'd1);
        if (aw_q.size() > 0) ga = aw_q.pop_front();
        if (wd_q.size() > 0) begin
            gd = wd_q.pop_front();
            gs = ws_q.pop_front();
        end
        chk({tag, "_awaddr"}, ga, a);
        chk({tag, "_wdata"}, gd, d);
        chk({tag, "_wstrb"}, 64'(gs), 64'(s));
    endtask

    initial begin
        int n;

        // Reset values
        repeat (3) @(negedge i_clk);
        chk("rst_msi_ready", 64'(o_msi_ready), 64'd1);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_awvalid", 64'(o_awvalid), 64'd0);
        chk("rst_wvalid", 64'(o_wvalid), 64'd0);
        chk("rst_bready", 64'(o_bready), 64'd0);
        chk("rst_err", 64'(o_err), 64'd0);
        chk("rst_awaddr", o_awaddr, 64'd0);
        chk("rst_wdata", o_wdata, 64'd0);
        chk("rst_wstrb", 64'(o_wstrb), 64'd0);
        @(posedge i_clk);
        #1;
        ni_rst = 1'b1;

        // Single request, lower lane, latency of two edges
        b_lat = 2;
        @(posedge i_clk);
        #1;
        i_msi_valid = 1'b1;
        i_msi_addr  = 64'h2800_0000;
        i_msi_eiid  = 11'd5;
        @(negedge i_clk);
        chk("t1_ready", 64'(o_msi_ready), 64'd1);
        @(posedge i_clk);
        #1;
        i_msi_valid = 1'b0;
        @(negedge i_clk);
        chk("t1_awvalid_not_early", 64'(o_awvalid), 64'd0);
        chk("t1_busy", 64'(o_busy), 64'd1);
        @(negedge i_clk);
        chk("t1_awvalid", 64'(o_awvalid), 64'd1);
        chk("t1_wvalid", 64'(o_wvalid), 64'd1);
        chk("t1_wlast", 64'(o_wlast), 64'd1);
        chk("t1_awaddr_live", o_awaddr, 64'h2800_0000);
        chk("t1_wdata_live", o_wdata, 64'h0000_0005_0000_0005);
        chk("t1_wstrb_live", 64'(o_wstrb), 64'h0F);
        wait_idle("t1_idle");
        chk_write("t1", 64'h2800_0000, 64'h0000_0005_0000_0005, 8'h0F);
        chk("t1_no_err", 64'(err_cnt), 64'd0);
        b_lat = 1;

        // Upper lane, maximum EIID
        push(64'h2800_1004, 11'h7FF);
        wait_idle("t2_idle");
        chk_write("t2", 64'h2800_1004, 64'h0000_07FF_0000_07FF, 8'hF0);

        // Independent handshakes: W accepted at once, AW stalled for 5 cycles
        i_awready = 1'b0;
        push(64'h2800_2008, 11'h123);
        n = 0;
        @(negedge i_clk);
        while (!o_awvalid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("t3_awvalid_rise", 64'(o_awvalid), 64'd1);
        chk("t3_wvalid_rise", 64'(o_wvalid), 64'd1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge i_clk);
            chk("t3_aw_held", 64'(o_awvalid), 64'd1);
            chk("t3_w_dropped", 64'(o_wvalid), 64'd0);
            chk("t3_awaddr_stable", o_awaddr, 64'h2800_2008);
        end
        @(posedge i_clk);
        #1;
        i_awready = 1'b1;
        @(negedge i_clk);
        chk("t3_aw_before_hs", 64'(o_awvalid), 64'd1);
        chk("t3_bready_not_yet", 64'(o_bready), 64'd0);
        @(negedge i_clk);
        chk("t3_aw_after_hs", 64'(o_awvalid), 64'd0);
        chk("t3_bready", 64'(o_bready), 64'd1);
        wait_idle("t3_idle");
        chk_write("t3", 64'h2800_2008, 64'h0000_0123_0000_0123, 8'h0F);

        // Full queue: B held off, 4 queued + 1 in flight blocks a sixth request
        b_en = 1'b0;
        for (int i = 0; i < 5; i++) push(T4_ADDR[i], T4_EIID[i]);
        i_msi_valid = 1'b1;
        i_msi_addr  = 64'h2800_9000;
        i_msi_eiid  = 11'd9;
        @(negedge i_clk);
        chk("t4_ready_full", 64'(o_msi_ready), 64'd0);
        chk("t4_bready", 64'(o_bready), 64'd1);
        @(negedge i_clk);
        chk("t4_ready_still_full", 64'(o_msi_ready), 64'd0);
        chk("t4_busy", 64'(o_busy), 64'd1);
        @(posedge i_clk);
        #1;
        i_msi_valid = 1'b0;
        b_en = 1'b1;
        wait_idle("t4_idle");
        chk("t4_count", 64'(aw_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) chk_write("t4", T4_ADDR[i], T4_DATA[i], T4_STRB[i]);

        // Error response on the first of two queued requests
        b_en = 1'b0;
        push(64'h2800_5000, 11'h010);
        push(64'h2800_6004, 11'h020);
        n = 0;
        @(negedge i_clk);
        while (!o_bready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("t5_bready", 64'(o_bready), 64'd1);
        @(posedge i_clk);
        #1;
        b_resp_v = 2'b10;
        b_en = 1'b1;
        n = 0;
        @(negedge i_clk);
        while (!o_err && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        chk("t5_err_pulse", 64'(o_err), 64'd1);
        chk("t5_idle_awvalid", 64'(o_awvalid), 64'd0);
        chk("t5_busy", 64'(o_busy), 64'd1);
        @(posedge i_clk);
        #1;
        b_resp_v = 2'b00;
        @(negedge i_clk);
        chk("t5_err_one_cycle", 64'(o_err), 64'd0);
        chk("t5_next_issued", 64'(o_awvalid), 64'd1);
        chk("t5_next_awaddr", o_awaddr, 64'h2800_6004);
        wait_idle("t5_idle");
        chk("t5_err_count", 64'(err_cnt), 64'd1);
        chk_write("t5a", 64'h2800_5000, 64'h0000_0010_0000_0010, 8'h0F);
        chk_write("t5b", 64'h2800_6004, 64'h0000_0020_0000_0020, 8'hF0);

        // Asynchronous reset in SEND with 3 requests queued
        i_awready = 1'b0;
        i_wready  = 1'b0;
        for (int i = 0; i < 4; i++) push(64'h2800_A000 + 64'(i * 4), 11'(i + 7));
        @(negedge i_clk);
        chk("t6_in_send", 64'(o_awvalid), 64'd1);
        chk("t6_full_queue_busy", 64'(o_busy), 64'd1);
        #2;
        ni_rst = 1'b0;
        #1;
        chk("t6_awvalid_async", 64'(o_awvalid), 64'd0);
        chk("t6_wvalid_async", 64'(o_wvalid), 64'd0);
        chk("t6_bready_async", 64'(o_bready), 64'd0);
        chk("t6_busy_async", 64'(o_busy), 64'd0);
        chk("t6_ready_async", 64'(o_msi_ready), 64'd1);
        chk("t6_awaddr_async", o_awaddr, 64'd0);
        @(posedge i_clk);
        #1;
        ni_rst    = 1'b1;
        i_awready = 1'b1;
        i_wready  = 1'b1;
        repeat (10) @(negedge i_clk);
        chk("t6_no_aw_after", 64'(aw_q.size()), 64'd0);
        chk("t6_no_w_after", 64'(wd_q.size()), 64'd0);
        chk("t6_idle_after", 64'(o_busy), 64'd0);
        chk("t6_err_count", 64'(err_cnt), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
